// File: rtl/riscV_unrn_pkg.sv
// riscV_unrn_pkg: shared memory map, access-size encoding and timer address decode
package riscV_unrn_pkg;
  localparam logic [31:0] MTIME_MEM_ADDRESS_LOW     = 32'h0000_8004;
  localparam logic [31:0] MTIME_MEM_ADDRESS_HIGH    = 32'h0000_8008;
  localparam logic [31:0] MTIMECMP_MEM_ADDRESS_LOW  = 32'h0000_800C;
  localparam logic [31:0] MTIMECMP_MEM_ADDRESS_HIGH = 32'h0000_8010;
  localparam logic [63:0] MTIMECMP_RESET_VAL        = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI
  } timer_sel_e;
  function automatic timer_sel_e timer_decode(input logic [31:0] addr);
    return addr == MTIME_MEM_ADDRESS_LOW     ? SEL_MTIME_LO    :
           addr == MTIME_MEM_ADDRESS_HIGH    ? SEL_MTIME_HI    :
           addr == MTIMECMP_MEM_ADDRESS_LOW  ? SEL_MTIMECMP_LO :
           addr == MTIMECMP_MEM_ADDRESS_HIGH ? SEL_MTIMECMP_HI : SEL_NONE;
  endfunction
endpackage

// File: rtl/machine_timer_prescaler.sv
// machine_timer_prescaler: divides the core clock into one-cycle mtime ticks every PRESCALE cycles
module machine_timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == 16'(PRESCALE - 1);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/machine_timer.sv
// machine_timer: RISC-V mtime/mtimecmp with mtip; MACHINE_TIMER_MTIME_WR_EN makes mtime writable
module machine_timer
  import riscV_unrn_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mtip
);
  logic        tick, legal, wr;
  timer_sel_e  sel;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, mtip_q, mtip_d;
  machine_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );
  always_comb begin
    sel = timer_decode(req_addr);
`ifdef MACHINE_TIMER_MTIME_WR_EN
    legal = req_size == WORD && sel != SEL_NONE;
`else
    legal = req_size == WORD && sel != SEL_NONE &&
            !(req_we && (sel == SEL_MTIME_LO || sel == SEL_MTIME_HI));
`endif
    wr = req_valid && req_we && legal;
    // a store into mtime overrides the tick increment for that cycle
    mtime_d = wr && sel == SEL_MTIME_LO ? {mtime_q[63:32], req_wdata} :
              wr && sel == SEL_MTIME_HI ? {req_wdata, mtime_q[31:0]} :
              tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = wr && sel == SEL_MTIMECMP_LO ? {mtimecmp_q[63:32], req_wdata} :
                 wr && sel == SEL_MTIMECMP_HI ? {req_wdata, mtimecmp_q[31:0]} : mtimecmp_q;
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid && !legal;
    rsp_rdata_d = !(req_valid && !req_we && legal) ? 32'd0 :
                  sel == SEL_MTIME_LO    ? mtime_q[31:0]     :
                  sel == SEL_MTIME_HI    ? mtime_q[63:32]    :
                  sel == SEL_MTIMECMP_LO ? mtimecmp_q[31:0]  : mtimecmp_q[63:32];
    mtip_d = mtime_d >= mtimecmp_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RESET_VAL;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mtip_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mtip_q      <= mtip_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mtip      = mtip_q;
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: scoreboard bench driving PRESCALE=1 and PRESCALE=4 timers with shared stimulus
module tb_machine_timer;
  logic        clk, rst, req_valid, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rv1, er1, ip1, rv4, er4, ip4;
  logic [31:0] rd1, rd4;
  int          n_chk, n_err;
  logic [32:0] q1[$], q4[$];
  logic [32:0] e1, e4;
  logic [63:0] m_time[2], m_cmp[2], nt;
  int          m_pre[2];
  logic        m_mip[2], tk, ok;
  logic [31:0] rd;

  machine_timer #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(er1), .mtip(ip1)
  );
  machine_timer #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv4), .rsp_rdata(rd4),
    .rsp_err(er4), .mtip(ip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one entry per timer, responses queued at the accepting edge
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_time[i] = '0;
        m_cmp[i]  = '1;
        m_pre[i]  = 0;
        m_mip[i]  = 1'b0;
      end else begin
        tk = m_pre[i] == (i == 0 ? 1 : 4) - 1;
        m_pre[i] = tk ? 0 : m_pre[i] + 1;
        ok = req_size == 2'b10 && req_addr inside {32'h8004, 32'h8008, 32'h800C, 32'h8010};
`ifndef MACHINE_TIMER_MTIME_WR_EN
        if (req_we && (req_addr == 32'h8004 || req_addr == 32'h8008)) ok = 1'b0;
`endif
        rd = '0;
        if (req_valid && ok && !req_we)
          case (req_addr)
            32'h8004: rd = m_time[i][31:0];
            32'h8008: rd = m_time[i][63:32];
            32'h800C: rd = m_cmp[i][31:0];
            default:  rd = m_cmp[i][63:32];
          endcase
        if (req_valid) begin
          if (i == 0) q1.push_back({~ok, rd});
          else        q4.push_back({~ok, rd});
        end
        nt = tk ? m_time[i] + 64'd1 : m_time[i];
        if (req_valid && ok && req_we)
          case (req_addr)
            32'h8004: nt[31:0] = req_wdata;
            32'h8008: nt[63:32] = req_wdata;
            32'h800C: m_cmp[i][31:0] = req_wdata;
            default:  m_cmp[i][63:32] = req_wdata;
          endcase
        m_time[i] = nt;
        m_mip[i]  = nt >= m_cmp[i];
      end
    end
    if (rst) begin
      q1.delete();
      q4.delete();
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("p1_rsp_valid", 64'(rv1), 64'd1);
      check("p1_rsp_rdata", 64'(rd1), 64'(e1[31:0]));
      check("p1_rsp_err", 64'(er1), 64'(e1[32]));
    end else check("p1_no_rsp", 64'(rv1), 64'd0);
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("p4_rsp_valid", 64'(rv4), 64'd1);
      check("p4_rsp_rdata", 64'(rd4), 64'(e4[31:0]));
      check("p4_rsp_err", 64'(er4), 64'(e4[32]));
    end else check("p4_no_rsp", 64'(rv4), 64'd0);
    check("p1_mtip", 64'(ip1), 64'(m_mip[0]));
    check("p4_mtip", 64'(ip4), 64'(m_mip[1]));
  end

  task automatic acc(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b10;
    req_addr = '0;
    req_wdata = '0;
    idle(3);
    rst = 1'b0;
    check("reset_rsp_valid", 64'(rv1), 64'd0);
    check("reset_rdata", 64'(rd1), 64'd0);
    check("reset_mtip", 64'(ip1), 64'd0);
    idle(10);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("mtime_lo_after_10", 64'(rd1), 64'd10);
    check("mtime_lo_err", 64'(er1), 64'd0);
    acc(1'b0, 2'b10, 32'h8008, 0);
    check("mtime_hi_zero", 64'(rd1), 64'd0);
    check("mtip_low_early", 64'(ip1), 64'd0);
    acc(1'b1, 2'b10, 32'h800C, 32'd20);
    acc(1'b1, 2'b10, 32'h8010, 32'd0);
    idle(10);
    check("mtip_raised", 64'(ip1), 64'd1);
    acc(1'b1, 2'b10, 32'h800C, 32'hFFFF_FFFF);
    check("mtip_cleared", 64'(ip1), 64'd0);
    check("cmp_store_err", 64'(er1), 64'd0);
    acc(1'b0, 2'b00, 32'h8004, 0);
    check("byte_load_err", 64'(er1), 64'd1);
    check("byte_load_rdata", 64'(rd1), 64'd0);
    acc(1'b0, 2'b10, 32'h8000, 0);
    check("bad_addr_err", 64'(er1), 64'd1);
    acc(1'b1, 2'b10, 32'h8014, 32'h1234);
    check("bad_store_err", 64'(er1), 64'd1);
    acc(1'b0, 2'b11, 32'h800C, 0);
    check("reserved_size_err", 64'(er1), 64'd1);
    acc(1'b0, 2'b10, 32'h800C, 0);
    check("cmp_unchanged", 64'(rd1), 64'hFFFF_FFFF);
`ifdef MACHINE_TIMER_MTIME_WR_EN
    acc(1'b1, 2'b10, 32'h8010, 32'hFFFF_FFFF);
    acc(1'b1, 2'b10, 32'h8008, 32'hFFFF_FFFF);
    acc(1'b1, 2'b10, 32'h8004, 32'hFFFF_FFFE);
    idle(2);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("wrap_lo", 64'(rd1), 64'd0);
    acc(1'b0, 2'b10, 32'h8008, 0);
    check("wrap_hi", 64'(rd1), 64'd0);
    check("wrap_no_mtip", 64'(ip1), 64'd0);
    acc(1'b1, 2'b10, 32'h8004, 32'h1234);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("store_beats_tick", 64'(rd1), 64'h1234);
`else
    acc(1'b1, 2'b10, 32'h8004, 32'd5);
    check("ro_mtime_err", 64'(er1), 64'd1);
    acc(1'b1, 2'b10, 32'h8008, 32'd5);
    check("ro_mtime_hi_err", 64'(er1), 64'd1);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("ro_mtime_counting", 64'(rd1 > 32'd5), 64'd1);
`endif
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      a = 32'h8000 + 32'($urandom_range(0, 5)) * 4;
      acc(1'($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
          a, (a == 32'h8010) ? 32'd0 : $urandom);
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(40);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("p4_mtime_after_40", 64'(rd4), 64'd10);
    check("p1_mtime_after_40", 64'(rd1), 64'd40);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b10;
    req_addr = 32'h8004;
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", 64'(rv4), 64'd0);
    check("rst_mid_rdata", 64'(rd4), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    idle(3);
    check("post_rst_no_rsp", 64'(rv4), 64'd0);
    check("post_rst_mtip", 64'(ip4), 64'd0);
    acc(1'b0, 2'b10, 32'h8010, 0);
    check("post_rst_cmp_hi", 64'(rd4), 64'hFFFF_FFFF);
    acc(1'b0, 2'b10, 32'h800C, 0);
    check("post_rst_cmp_lo", 64'(rd4), 64'hFFFF_FFFF);
    acc(1'b0, 2'b10, 32'h8004, 0);
    check("post_rst_p4_mtime", 64'(rd4), 64'd1);
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
